// File: rtl/openfire_fsl_ctrl_if.sv
`default_nettype none
// ============================================================================
// openfire_fsl_ctrl_if : command, FSL master/slave and status bundle
// Rev 1.0
// ============================================================================
interface openfire_fsl_ctrl_if #(
  parameter int D_WIDTH = 32,
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
);
  logic                        stall;
  logic                        cmd_vld;
  logic                        cmd_get;
  logic                        cmd_blocking;
  logic                        cmd_control;
  logic [CH_BITS-1:0]          cmd_ch;
  logic [D_WIDTH-1:0]          cmd_data;

  logic [NUM_CH-1:0]           fsl_m_full;
  logic [NUM_CH-1:0]           fsl_m_write;
  logic [D_WIDTH-1:0]          fsl_m_data;
  logic                        fsl_m_control;

  logic [NUM_CH-1:0]           fsl_s_exists;
  logic [NUM_CH-1:0]           fsl_s_control;
  logic [NUM_CH*D_WIDTH-1:0]   fsl_s_data;
  logic [NUM_CH-1:0]           fsl_s_read;

  logic [D_WIDTH-1:0]          get_data;
  logic                        we_regfile;
  logic                        instr_complete;
  logic                        carry_we;
  logic                        carry_val;
  logic                        fsl_err;

  // master: the controller; slave: execute stage plus FSL FIFOs
  modport master (
    input  stall, cmd_vld, cmd_get, cmd_blocking, cmd_control, cmd_ch, cmd_data,
    input  fsl_m_full, fsl_s_exists, fsl_s_control, fsl_s_data,
    output fsl_m_write, fsl_m_data, fsl_m_control, fsl_s_read,
    output get_data, we_regfile, instr_complete, carry_we, carry_val, fsl_err
  );

  modport slave (
    output stall, cmd_vld, cmd_get, cmd_blocking, cmd_control, cmd_ch, cmd_data,
    output fsl_m_full, fsl_s_exists, fsl_s_control, fsl_s_data,
    input  fsl_m_write, fsl_m_data, fsl_m_control, fsl_s_read,
    input  get_data, we_regfile, instr_complete, carry_we, carry_val, fsl_err
  );
endinterface
`default_nettype wire

// File: rtl/openfire_fsl_ctrl.sv
`default_nettype none
// ============================================================================
// openfire_fsl_ctrl : multi-channel FSL get/put controller (IDLE/WAIT/DONE)
// Optional macro FSL_TIMEOUT_EN bounds blocking waits to TIMEOUT cycles.
// Rev 1.0
// ============================================================================
module openfire_fsl_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_BITS = 8
) (
  input  wire logic           clock,
  input  wire logic           reset_n,
  openfire_fsl_ctrl_if.master bus
);

  if ((NUM_CH < 1) || (NUM_CH > 16) || ((1 << CH_BITS) < NUM_CH)) begin : g_bad_ch_cfg
    $error("openfire_fsl_ctrl: NUM_CH/CH_BITS out of range");
  end
  if ((TIMEOUT < 1) || ((1 << TO_BITS) <= TIMEOUT)) begin : g_bad_to_cfg
    $error("openfire_fsl_ctrl: TIMEOUT does not fit in TO_BITS");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;

  logic               get_q, get_d;
  logic               blk_q, blk_d;
  logic               ctl_q, ctl_d;
  logic [CH_BITS-1:0] ch_q, ch_d;
  logic [D_WIDTH-1:0] data_q, data_d;

  logic [NUM_CH-1:0]  m_write_q, m_write_d;
  logic [NUM_CH-1:0]  s_read_q, s_read_d;
  logic               we_q, we_d;
  logic               carry_we_q, carry_we_d;
  logic               carry_val_q, carry_val_d;
  logic [D_WIDTH-1:0] m_data_q, m_data_d;
  logic               m_ctl_q, m_ctl_d;
  logic [D_WIDTH-1:0] get_data_q, get_data_d;
  logic               fsl_err_q, fsl_err_d;

  logic               in_idle;
  logic               accept;
  logic               wait_go;
  logic               eff_get, eff_blk, eff_ctl;
  logic [CH_BITS-1:0] eff_ch;
  logic [D_WIDTH-1:0] eff_data;

  logic               ch_ok;
  logic [NUM_CH-1:0]  ch_onehot;
  logic               m_full_sel;
  logic               s_exists_sel;
  logic               s_ctl_sel;
  logic [D_WIDTH-1:0] s_data_sel;
  logic               ready;
  logic               xfer;
  logic               fail_now;
  logic               to_expire;

  assign in_idle = (state_q == S_IDLE);
  assign accept  = in_idle & bus.cmd_vld & ~bus.stall;
  assign wait_go = (state_q == S_WAIT) & ~bus.stall;

  // Accept cycle works from the live command; WAIT works from the latched copy.
  assign eff_get  = in_idle ? bus.cmd_get      : get_q;
  assign eff_blk  = in_idle ? bus.cmd_blocking : blk_q;
  assign eff_ctl  = in_idle ? bus.cmd_control  : ctl_q;
  assign eff_ch   = in_idle ? bus.cmd_ch       : ch_q;
  assign eff_data = in_idle ? bus.cmd_data     : data_q;

  // Channels at or beyond NUM_CH match no entry and so are never ready.
  always_comb begin
    ch_ok        = 1'b0;
    ch_onehot    = '0;
    m_full_sel   = 1'b1;
    s_exists_sel = 1'b0;
    s_ctl_sel    = 1'b0;
    s_data_sel   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (eff_ch == CH_BITS'(k)) begin
        ch_ok        = 1'b1;
        ch_onehot[k] = 1'b1;
        m_full_sel   = bus.fsl_m_full[k];
        s_exists_sel = bus.fsl_s_exists[k];
        s_ctl_sel    = bus.fsl_s_control[k];
        s_data_sel   = bus.fsl_s_data[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign ready    = ch_ok & (eff_get ? s_exists_sel : ~m_full_sel);
  assign xfer     = (accept | wait_go) & ready;
  assign fail_now = accept & ~ready & (~eff_blk | ~ch_ok);

`ifdef FSL_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_expire = 1'b0;
    if (in_idle) begin
      to_cnt_d = '0;
    end else if (wait_go) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (!ready && (to_cnt_d == TO_BITS'(TIMEOUT))) begin
        to_expire = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_expire = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (xfer | fail_now) ? S_DONE : S_WAIT;
      S_WAIT:  if (xfer | to_expire) state_d = S_DONE;
      S_DONE:  if (!bus.stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; strobes are produced only on the edge entering DONE
  always_comb begin
    m_write_d   = '0;
    s_read_d    = '0;
    we_d        = 1'b0;
    carry_we_d  = 1'b0;
    carry_val_d = 1'b0;
    m_data_d    = m_data_q;
    m_ctl_d     = m_ctl_q;
    get_data_d  = get_data_q;
    fsl_err_d   = fsl_err_q;
    if (xfer) begin
      if (eff_get) begin
        s_read_d   = ch_onehot;
        we_d       = 1'b1;
        get_data_d = s_data_sel;
        fsl_err_d  = s_ctl_sel ^ eff_ctl;
      end else begin
        m_write_d  = ch_onehot;
        m_data_d   = eff_data;
        m_ctl_d    = eff_ctl;
      end
      carry_we_d = ~eff_blk;
    end
    if (fail_now | to_expire) begin
      carry_we_d  = 1'b1;
      carry_val_d = 1'b1;
    end
    if (to_expire) begin
      fsl_err_d = 1'b1;
    end
  end

  always_comb begin
    get_d  = get_q;
    blk_d  = blk_q;
    ctl_d  = ctl_q;
    ch_d   = ch_q;
    data_d = data_q;
    if (accept) begin
      get_d  = bus.cmd_get;
      blk_d  = bus.cmd_blocking;
      ctl_d  = bus.cmd_control;
      ch_d   = bus.cmd_ch;
      data_d = bus.cmd_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      get_q  <= 1'b0;
      blk_q  <= 1'b0;
      ctl_q  <= 1'b0;
      ch_q   <= '0;
      data_q <= '0;
    end else begin
      get_q  <= get_d;
      blk_q  <= blk_d;
      ctl_q  <= ctl_d;
      ch_q   <= ch_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_write_q   <= '0;
      s_read_q    <= '0;
      we_q        <= 1'b0;
      carry_we_q  <= 1'b0;
      carry_val_q <= 1'b0;
      m_data_q    <= '0;
      m_ctl_q     <= 1'b0;
      get_data_q  <= '0;
      fsl_err_q   <= 1'b0;
    end else begin
      m_write_q   <= m_write_d;
      s_read_q    <= s_read_d;
      we_q        <= we_d;
      carry_we_q  <= carry_we_d;
      carry_val_q <= carry_val_d;
      m_data_q    <= m_data_d;
      m_ctl_q     <= m_ctl_d;
      get_data_q  <= get_data_d;
      fsl_err_q   <= fsl_err_d;
    end
  end

  assign bus.fsl_m_write    = m_write_q;
  assign bus.fsl_m_data     = m_data_q;
  assign bus.fsl_m_control  = m_ctl_q;
  assign bus.fsl_s_read     = s_read_q;
  assign bus.get_data       = get_data_q;
  assign bus.we_regfile     = we_q;
  assign bus.carry_we       = carry_we_q;
  assign bus.carry_val      = carry_val_q;
  assign bus.fsl_err        = fsl_err_q;
  assign bus.instr_complete = ~bus.cmd_vld | (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/openfire_fsl_ctrl.md
# openfire_fsl_ctrl

Multi-channel Fast Simplex Link (FSL) command controller for the OpenFire execute stage. Accepts decoded get/put commands on any of `NUM_CH` master/slave FSL channel pairs, supports blocking and non-blocking forms, and reports completion, regfile write-back, carry and FSL-error status to the execute/pipeline control logic. It replaces single-channel inline FSL handling with a parametrised, stall-aware state machine.

## Interface
- `D_WIDTH`, 32, datapath and FSL data width
- `NUM_CH`, 4, number of FSL channel pairs (1..16)
- `CH_BITS`, 2, width of channel index; 2^CH_BITS >= NUM_CH
- `TIMEOUT`, 255, blocking-wait cycle limit (used only with `FSL_TIMEOUT_EN`)
- `TO_BITS`, 8, timeout counter width; 2^TO_BITS > TIMEOUT

- `clock`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  pipeline stall; freezes state transitions
- `cmd_vld`  in  1  FSL instruction in execute; held until `instr_complete`
- `cmd_get`  in  1  1 = get, 0 = put
- `cmd_blocking`  in  1  1 = blocking form
- `cmd_control`  in  1  control-bit form of instruction
- `cmd_ch`  in  CH_BITS  target channel
- `cmd_data`  in  D_WIDTH  put data (regA)
- `fsl_m_full`  in  NUM_CH  master FIFO full, per channel
- `fsl_m_write`  out  NUM_CH  master write strobe, one-hot
- `fsl_m_data`  out  D_WIDTH  master write data, shared
- `fsl_m_control`  out  1  master control bit, shared
- `fsl_s_exists`  in  NUM_CH  slave data available, per channel
- `fsl_s_control`  in  NUM_CH  slave control bit, per channel
- `fsl_s_data`  in  NUM_CH*D_WIDTH  slave data, channel k at [k*D_WIDTH +: D_WIDTH]
- `fsl_s_read`  out  NUM_CH  slave read strobe, one-hot
- `get_data`  out  D_WIDTH  captured get data
- `we_regfile`  out  1  write `get_data` to rD
- `instr_complete`  out  1  combinational: `~cmd_vld | (state==DONE)`
- `carry_we`, `carry_val`  out  1,1  MSR[C] update strobe and value
- `fsl_err`  out  1  MSR FSL-error bit (held)

## Operation
- States: IDLE, WAIT, DONE. Command fields latched on IDLE accept (`cmd_vld & ~stall`); WAIT uses latched copy.
- "Ready": put = `~fsl_m_full[ch]`; get = `fsl_s_exists[ch]`. `ch >= NUM_CH` is never ready.
- Transfer (ready): put drives `fsl_m_write[ch]`, `fsl_m_data`, `fsl_m_control`; get drives `fsl_s_read[ch]`, captures `fsl_s_data[ch]` into `get_data`, asserts `we_regfile`, sets `fsl_err = fsl_s_control[ch] ^ cmd_control`.
- IDLE accept: ready -> transfer, DONE. Not ready & non-blocking -> DONE, no transfer. Not ready & blocking & ch < NUM_CH -> WAIT. ch >= NUM_CH -> DONE, no transfer, `carry_val=1` (even if blocking).
- Non-blocking always pulses `carry_we`; `carry_val` = 0 on transfer, 1 on failure. Blocking success does not touch carry.
- WAIT: re-evaluates ready each non-stalled cycle; ready -> transfer, DONE.
- DONE: `~stall` -> IDLE. Puts and failed gets leave `fsl_err` unchanged.

## Timing
- Strobes (`fsl_m_write`, `fsl_s_read`, `we_regfile`, `carry_we`) registered; high exactly the first cycle in DONE, cleared next edge even if stalled.
- Non-blocking or immediately-ready: issue cycle N, strobes + `instr_complete` in N+1, IDLE in N+2 (no stall).
- Blocking: completes cycle after ready observed in WAIT.
- `stall` high: no transitions, timeout counter frozen.
- Reset (any time, incl. mid-WAIT): state IDLE, all outputs 0, `get_data` 0, `fsl_err` 0; no strobe issued.
- Back-to-back commands: new command accepted in IDLE cycle after DONE.

## Configuration
- `FSL_TIMEOUT_EN` defined: WAIT counts non-stalled cycles; at count == `TIMEOUT` without ready -> DONE, no transfer, `carry_we=1`, `carry_val=1`, `fsl_err=1`. Counter clears on entering WAIT.
- Undefined: WAIT is indefinite; `TIMEOUT`/`TO_BITS` unused, no counter logic.

## Test plan
- Non-blocking put ch2, `fsl_m_full=4'b0000`, data 0xDEADBEEF -> `fsl_m_write=4'b0100` one cycle, `fsl_m_data=0xDEADBEEF`, carry_val=0, complete at N+1.
- Non-blocking get ch1, `fsl_s_exists=0` -> no `fsl_s_read`, `we_regfile=0`, carry_we=1/carry_val=1, `fsl_err` unchanged.
- Blocking get ch3, exists rises after 5 cycles, s_control=1, cmd_control=0 -> `fsl_s_read=4'b1000` one cycle, `get_data` = ch3 data, `we_regfile=1`, `fsl_err=1`, no carry_we.
- Stall held 3 cycles in DONE after put -> `fsl_m_write` high 1 cycle only; `instr_complete` high throughout; IDLE after stall drops.
- `reset_n` low during WAIT -> immediate IDLE, all outputs 0; later exists=1 produces no read.
- With `FSL_TIMEOUT_EN`, `TIMEOUT=10`, blocking put to permanently full ch0 -> DONE after 10 WAIT cycles, carry_val=1, fsl_err=1, no write.
